cpu_run_ctrl: RTL and testbench

Run controller that sequences the Beta CPU core. It turns the `runCPU` start pulse into a clean core reset followed by clock-enabled execution. It supports pause, single-step and resume. It ends a run on a decoded HALT/illegal-op or on a cycle budget. It sits between the top-level control inputs and the `CPU` core, gating the core's state-update enable and driving its synchronous clear.

---
 rtl/cpu_run_ctrl_if.sv | 28 ++
 rtl/cpu_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the top-level run controls, the CPU core and
// the run controller. The master side is whoever drives the run requests and
// the core's halted flag; the slave side is cpu_run_ctrl.
interface cpu_run_ctrl_if #(
    parameter int CW = 32
);
    logic          runCPU;
    logic          step;
    logic          halt_req;
    logic          halted_in;
    logic          cpu_en;
    logic          cpu_reset;
    logic          busy;
    logic          paused;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    modport master (
        output runCPU, step, halt_req, halted_in,
        input  cpu_en, cpu_reset, busy, paused, done, timeout, cycle_count
    );

    modport slave (
        input  runCPU, step, halt_req, halted_in,
        output cpu_en, cpu_reset, busy, paused, done, timeout, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the Beta CPU core: turns a runCPU edge into a core clear
// followed by clock-enabled execution, with pause / single-step / resume and
// termination on HALT/ILLOP or an optional enabled-cycle budget.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | after reset, waiting for a runCPU edge
//   S_CLEAR | cpu_reset held for RST_CYCLES cycles
//   S_RUN   | core enabled every cycle
//   S_PAUSE | core frozen, waiting for resume or a step edge
//   S_STEP  | core enabled for exactly one cycle, then back to pause
//   S_DONE  | run finished (halt/illegal op or budget), waiting for a new run
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int CW         = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_STEP,
        S_DONE
    } state_t;

    localparam int               CLR_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST    = CLR_W'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    BUDGET_LAST = CW'(MAX_CYCLES - 1);
    localparam bit               HAS_BUDGET  = (MAX_CYCLES != 0);

    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic             step_q, step_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]    cycle_count_q, cycle_count_d;
    logic             timeout_q, timeout_d;
    logic             cpu_en_q, cpu_en_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             busy_q, busy_d;
    logic             paused_q, paused_d;
    logic             done_q, done_d;

    logic start;
    logic stp;
    logic budget_hit;

    // Next-state, counters and Moore outputs decoded from the next state so
    // every output comes straight from a flop.
    always_comb begin
        start      = bus.runCPU & ~run_q;
        stp        = bus.step & ~step_q;
        // Checked against the pre-increment count: the cycle now executing is
        // the last one the budget allows.
        budget_hit = HAS_BUDGET && (cycle_count_q == BUDGET_LAST);

        state_d       = state_q;
        run_d         = bus.runCPU;
        step_d        = bus.step;
        clr_cnt_d     = clr_cnt_q;
        timeout_d     = timeout_q;
        cycle_count_d = cpu_en_q ? cycle_count_q + CW'(1) : cycle_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_CLEAR;
                    clr_cnt_d     = '0;
                    cycle_count_d = '0;
                    timeout_d     = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            S_RUN: begin
                if (bus.halted_in) begin
                    state_d = S_DONE;
                end else if (budget_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (bus.halt_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                // Resume wins over step; a held halt_req does not block it.
                if (start) begin
                    state_d = S_RUN;
                end else if (stp) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (bus.halted_in) begin
                    state_d = S_DONE;
                end else if (budget_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_en_d    = (state_d == S_RUN) || (state_d == S_STEP);
        cpu_reset_d = (state_d == S_CLEAR);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_STEP);
        paused_d    = (state_d == S_PAUSE);
        done_d      = (state_d == S_DONE);
    end

    // Controller state and registered outputs; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            run_q         <= 1'b0;
            step_q        <= 1'b0;
            clr_cnt_q     <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            cpu_en_q      <= 1'b0;
            cpu_reset_q   <= 1'b0;
            busy_q        <= 1'b0;
            paused_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            step_q        <= step_d;
            clr_cnt_q     <= clr_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            cpu_en_q      <= cpu_en_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
            paused_q      <= paused_d;
            done_q        <= done_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.busy        = busy_q;
    assign bus.paused      = paused_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances (unlimited budget, 10-cycle budget,
// 4-bit counter with 3 clear cycles) share the same stimulus and are compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run_cpu = 1'b0;
    logic step = 1'b0;
    logic halt_req = 1'b0;
    logic halted_in = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CW(32)) if_a ();
    cpu_run_ctrl_if #(.CW(32)) if_b ();
    cpu_run_ctrl_if #(.CW(4))  if_c ();

    assign if_a.runCPU = run_cpu;   assign if_a.step = step;
    assign if_a.halt_req = halt_req; assign if_a.halted_in = halted_in;
    assign if_b.runCPU = run_cpu;   assign if_b.step = step;
    assign if_b.halt_req = halt_req; assign if_b.halted_in = halted_in;
    assign if_c.runCPU = run_cpu;   assign if_c.step = step;
    assign if_c.halt_req = halt_req; assign if_c.halted_in = halted_in;

    cpu_run_ctrl #(.RST_CYCLES(2), .CW(32), .MAX_CYCLES(0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    cpu_run_ctrl #(.RST_CYCLES(2), .CW(32), .MAX_CYCLES(10))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    cpu_run_ctrl #(.RST_CYCLES(3), .CW(4), .MAX_CYCLES(0))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_PAUSE = 3, M_STEP = 4, M_DONE = 5;
    int p_rst [3] = '{2, 2, 3};
    int p_max [3] = '{0, 10, 0};
    int p_cw  [3] = '{32, 32, 4};

    int              m_phase [3];
    int              m_left  [3];
    longint unsigned m_cnt   [3];
    bit              m_to    [3];
    bit              m_rprev, m_sprev;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_phase[d] = M_IDLE; m_left[d] = 0; m_cnt[d] = 0; m_to[d] = 1'b0;
        end
        m_rprev = 1'b0; m_sprev = 1'b0;
    endtask

    task automatic model_step();
        bit start, stp, en, hit;
        start = run_cpu && !m_rprev;
        stp   = step && !m_sprev;
        for (int d = 0; d < 3; d++) begin
            en = (m_phase[d] == M_RUN) || (m_phase[d] == M_STEP);
            if (en) m_cnt[d] = (m_cnt[d] + 1) % (64'd1 << p_cw[d]);
            hit = en && (p_max[d] != 0) && (m_cnt[d] == longint'(p_max[d]));
            case (m_phase[d])
                M_IDLE, M_DONE:
                    if (start) begin
                        m_phase[d] = M_CLEAR; m_left[d] = p_rst[d];
                        m_cnt[d] = 0; m_to[d] = 1'b0;
                    end
                M_CLEAR: begin
                    m_left[d]--;
                    if (m_left[d] == 0) m_phase[d] = M_RUN;
                end
                M_RUN:
                    if (halted_in) m_phase[d] = M_DONE;
                    else if (hit) begin m_phase[d] = M_DONE; m_to[d] = 1'b1; end
                    else if (halt_req) m_phase[d] = M_PAUSE;
                M_PAUSE:
                    if (start) m_phase[d] = M_RUN;
                    else if (stp) m_phase[d] = M_STEP;
                M_STEP:
                    if (halted_in) m_phase[d] = M_DONE;
                    else if (hit) begin m_phase[d] = M_DONE; m_to[d] = 1'b1; end
                    else m_phase[d] = M_PAUSE;
                default: m_phase[d] = M_IDLE;
            endcase
        end
        m_rprev = run_cpu;
        m_sprev = step;
    endtask

    task automatic check_dut(input int d, input logic en, input logic rs, input logic bz,
                             input logic pa, input logic dn, input logic to,
                             input logic [31:0] cnt);
        int ph;
        ph = m_phase[d];
        check_val($sformatf("d%0d.cpu_en", d), 32'(en), 32'((ph == M_RUN) || (ph == M_STEP)));
        check_val($sformatf("d%0d.cpu_reset", d), 32'(rs), 32'(ph == M_CLEAR));
        check_val($sformatf("d%0d.busy", d), 32'(bz),
                  32'((ph == M_CLEAR) || (ph == M_RUN) || (ph == M_STEP)));
        check_val($sformatf("d%0d.paused", d), 32'(pa), 32'(ph == M_PAUSE));
        check_val($sformatf("d%0d.done", d), 32'(dn), 32'(ph == M_DONE));
        check_val($sformatf("d%0d.timeout", d), 32'(to), 32'(m_to[d]));
        check_val($sformatf("d%0d.cycle_count", d), cnt, 32'(m_cnt[d]));
    endtask

    task automatic compare_all();
        check_dut(0, if_a.cpu_en, if_a.cpu_reset, if_a.busy, if_a.paused, if_a.done,
                  if_a.timeout, if_a.cycle_count);
        check_dut(1, if_b.cpu_en, if_b.cpu_reset, if_b.busy, if_b.paused, if_b.done,
                  if_b.timeout, if_b.cycle_count);
        check_dut(2, if_c.cpu_en, if_c.cpu_reset, if_c.busy, if_c.paused, if_c.done,
                  if_c.timeout, 32'(if_c.cycle_count));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset pulse between edges, checked before the next clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        check_val("rst.cpu_en", 32'(if_a.cpu_en), 32'd0);
        check_val("rst.cpu_reset", 32'(if_a.cpu_reset), 32'd0);
        check_val("rst.busy", 32'(if_a.busy), 32'd0);
        check_val("rst.count", if_a.cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n_en, n_rs;
        bit saw_wrap;
        logic [3:0] prev_c;

        model_reset();
        repeat (2) cycle();
        check_val("init.done", 32'(if_a.done), 32'd0);
        reset = 1'b0;

        // Start, clear timing, halt after 5 RUN cycles.
        run_cpu = 1'b1; cycle();
        check_val("s1.clr0", 32'(if_a.cpu_reset), 32'd1);
        run_cpu = 1'b0; cycle();
        check_val("s1.clr1", 32'(if_a.cpu_reset), 32'd1);
        cycle();
        check_val("s1.run_en", 32'(if_a.cpu_en), 32'd1);
        check_val("s1.run_rs", 32'(if_a.cpu_reset), 32'd0);
        check_val("s1.run_busy", 32'(if_a.busy), 32'd1);
        repeat (4) cycle();
        halted_in = 1'b1; cycle(); halted_in = 1'b0;
        check_val("s1.done", 32'(if_a.done), 32'd1);
        check_val("s1.count", if_a.cycle_count, 32'd5);
        check_val("s1.en_off", 32'(if_a.cpu_en), 32'd0);

        // Budget of 10 on dut_b.
        do_reset();
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        n_en = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            n_en += int'(if_b.cpu_en);
        end
        check_val("s2.en_cycles", 32'(n_en), 32'd10);
        check_val("s2.done", 32'(if_b.done), 32'd1);
        check_val("s2.timeout", 32'(if_b.timeout), 32'd1);
        check_val("s2.count", if_b.cycle_count, 32'd10);
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        check_val("s2.to_clr", 32'(if_b.timeout), 32'd0);
        check_val("s2.cnt_clr", if_b.cycle_count, 32'd0);

        // Pause, two steps, resume without clear.
        do_reset();
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        repeat (4) cycle();
        halt_req = 1'b1; cycle();
        check_val("s3.paused", 32'(if_a.paused), 32'd1);
        check_val("s3.en_off", 32'(if_a.cpu_en), 32'd0);
        check_val("s3.count3", if_a.cycle_count, 32'd3);
        step = 1'b1; cycle();
        check_val("s3.step1_en", 32'(if_a.cpu_en), 32'd1);
        step = 1'b0; cycle();
        check_val("s3.step1_pause", 32'(if_a.paused), 32'd1);
        step = 1'b1; cycle();
        step = 1'b0; cycle();
        check_val("s3.count5", if_a.cycle_count, 32'd5);
        run_cpu = 1'b1; cycle();
        check_val("s3.resume_en", 32'(if_a.cpu_en), 32'd1);
        check_val("s3.resume_rs", 32'(if_a.cpu_reset), 32'd0);
        run_cpu = 1'b0; halt_req = 1'b0;

        // Held runCPU gives one clear; halted_in beats halt_req.
        do_reset();
        n_rs = 0;
        for (int i = 0; i < 8; i++) begin
            run_cpu = (i < 4);
            cycle();
            n_rs += int'(if_a.cpu_reset);
        end
        check_val("s4.clear_cycles", 32'(n_rs), 32'd2);
        halted_in = 1'b1; halt_req = 1'b1; cycle();
        halted_in = 1'b0; halt_req = 1'b0;
        check_val("s4.done", 32'(if_a.done), 32'd1);
        check_val("s4.not_paused", 32'(if_a.paused), 32'd0);

        // Reset mid-CLEAR and mid-RUN.
        do_reset();
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        do_reset();
        n_en = 0;
        repeat (5) begin cycle(); n_en += int'(if_a.cpu_en); end
        check_val("s5.no_en_clr", 32'(n_en), 32'd0);
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        repeat (4) cycle();
        do_reset();
        n_en = 0;
        repeat (5) begin cycle(); n_en += int'(if_a.cpu_en); end
        check_val("s5.no_en_run", 32'(n_en), 32'd0);

        // 4-bit counter wrap on dut_c.
        do_reset();
        run_cpu = 1'b1; cycle(); run_cpu = 1'b0;
        repeat (3) cycle();
        saw_wrap = 1'b0;
        for (int i = 0; i < 19; i++) begin
            prev_c = if_c.cycle_count;
            cycle();
            if (prev_c == 4'd15 && if_c.cycle_count == 4'd0) saw_wrap = 1'b1;
        end
        halted_in = 1'b1; cycle(); halted_in = 1'b0;
        check_val("s6.wrap", 32'(saw_wrap), 32'd1);
        check_val("s6.count", 32'(if_c.cycle_count), 32'd4);
        check_val("s6.timeout", 32'(if_c.timeout), 32'd0);
        check_val("s6.done", 32'(if_c.done), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            run_cpu   = ($urandom_range(0, 7) == 0);
            step      = ($urandom_range(0, 2) == 0);
            halt_req  = ($urandom_range(0, 9) == 0);
            halted_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
